// File: rtl/boa_stage_id.sv
// boa_stage_id: instruction-decode stage of the Boa32 RV32I pipeline.
// Holds one fetched instruction, decodes register indices, immediates and
// illegal opcodes, and issues a one-shot static branch prediction to fetch.
module boa_stage_id (
    input  logic        clk,
    input  logic        rst,
    input  logic        d_valid,
    input  logic [30:0] d_pc,
    input  logic [31:0] d_insn,
    input  logic        d_trap,
    input  logic [3:0]  d_cause,
    input  logic        fw_stall_id,
    input  logic        fw_branch_correct,
    output logic        id_branch_predict,
    output logic [30:0] id_branch_target,
    output logic        q_valid,
    output logic [30:0] q_pc,
    output logic [31:0] q_insn,
    output logic        q_trap,
    output logic [3:0]  q_cause,
    output logic [4:0]  q_rs1,
    output logic [4:0]  q_rs2,
    output logic [4:0]  q_rd,
    output logic        q_use_rs1,
    output logic        q_use_rs2,
    output logic [31:0] q_imm,
    output logic        q_predicted
);

    logic        r_valid;
    logic [30:0] r_pc;
    logic [31:0] r_insn;
    logic        r_trap;
    logic [3:0]  r_cause;
    logic        r_issued;

    logic        illegal;
    logic        use_rd;
    logic        is_jal;
    logic        is_branch;
    logic        pred_raw;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [30:0] tgt_off;

    // ID pipeline register: reset, flush, stall-hold or capture from fetch
    always_ff @(posedge clk) begin
        if (rst || fw_branch_correct) begin
            r_valid  <= 1'b0;
            r_issued <= 1'b0;
        end else if (fw_stall_id) begin
            r_issued <= r_issued | id_branch_predict;
        end else begin
            r_valid  <= d_valid;
            r_pc     <= d_pc;
            r_insn   <= d_insn;
            r_trap   <= d_trap;
            r_cause  <= d_cause;
            r_issued <= 1'b0;
        end
    end

    assign imm_i = {{20{r_insn[31]}}, r_insn[31:20]};
    assign imm_s = {{20{r_insn[31]}}, r_insn[31:25], r_insn[11:7]};
    assign imm_b = {{19{r_insn[31]}}, r_insn[31], r_insn[7], r_insn[30:25], r_insn[11:8], 1'b0};
    assign imm_u = {r_insn[31:12], 12'h000};
    assign imm_j = {{11{r_insn[31]}}, r_insn[31], r_insn[19:12], r_insn[20], r_insn[30:21], 1'b0};

    // Opcode decode: operand usage, immediate format and legality
    always_comb begin
        illegal   = 1'b0;
        q_use_rs1 = 1'b0;
        q_use_rs2 = 1'b0;
        use_rd    = 1'b0;
        is_jal    = 1'b0;
        is_branch = 1'b0;
        q_imm     = '0;
        if (r_insn[1:0] != 2'b11) begin
            illegal = 1'b1;
        end else begin
            case (r_insn[6:2])
                5'b01101, 5'b00101: begin            // LUI, AUIPC
                    use_rd = 1'b1;
                    q_imm  = imm_u;
                end
                5'b11011: begin                      // JAL
                    use_rd = 1'b1;
                    is_jal = 1'b1;
                    q_imm  = imm_j;
                end
                5'b11000: begin                      // BRANCH
                    q_use_rs1 = 1'b1;
                    q_use_rs2 = 1'b1;
                    is_branch = 1'b1;
                    q_imm     = imm_b;
                end
                5'b01000: begin                      // STORE
                    q_use_rs1 = 1'b1;
                    q_use_rs2 = 1'b1;
                    q_imm     = imm_s;
                end
                5'b01100: begin                      // OP
                    q_use_rs1 = 1'b1;
                    q_use_rs2 = 1'b1;
                    use_rd    = 1'b1;
                end
                5'b11001, 5'b00000, 5'b00100, 5'b00011, 5'b11100: begin  // JALR, LOAD, OP-IMM, MISC-MEM, SYSTEM
                    q_use_rs1 = 1'b1;
                    use_rd    = 1'b1;
                    q_imm     = imm_i;
                end
                default: illegal = 1'b1;
            endcase
        end
    end

    assign q_pc    = r_pc;
    assign q_insn  = r_insn;
    assign q_rs1   = q_use_rs1 ? r_insn[19:15] : '0;
    assign q_rs2   = q_use_rs2 ? r_insn[24:20] : '0;
    assign q_rd    = use_rd    ? r_insn[11:7]  : '0;
    assign q_valid = r_valid & ~fw_stall_id & ~fw_branch_correct;
    assign q_trap  = r_valid & (r_trap | illegal);
    assign q_cause = !r_valid ? 4'd0 : r_trap ? r_cause : illegal ? 4'd2 : 4'd0;

    // Backward conditional branches and all JALs are predicted taken
    assign pred_raw          = r_valid & ~r_trap & ~illegal & (is_jal | (is_branch & r_insn[31]));
    assign q_predicted       = pred_raw;
    assign id_branch_predict = pred_raw & ~r_issued & ~fw_branch_correct;
    assign tgt_off           = is_jal ? imm_j[31:1] : imm_b[31:1];
    assign id_branch_target  = r_pc + tgt_off;

endmodule

// File: tb/tb_boa_stage_id.sv
// Self-checking bench for boa_stage_id: directed cases plus randomized
// traffic compared every cycle against a behavioural model.
module tb_boa_stage_id;

    logic        clk, rst, d_valid, d_trap, fw_stall_id, fw_branch_correct;
    logic [30:0] d_pc;
    logic [31:0] d_insn;
    logic [3:0]  d_cause;
    logic        id_branch_predict, q_valid, q_trap, q_use_rs1, q_use_rs2, q_predicted;
    logic [30:0] id_branch_target, q_pc;
    logic [31:0] q_insn, q_imm;
    logic [3:0]  q_cause;
    logic [4:0]  q_rs1, q_rs2, q_rd;

    int checks = 0;
    int failures = 0;
    bit armed = 0;

    localparam logic [31:0] JAL8 = 32'h0080006F;
    localparam logic [31:0] ADDI = 32'h00000013;

    boa_stage_id dut (
        .clk(clk), .rst(rst), .d_valid(d_valid), .d_pc(d_pc), .d_insn(d_insn),
        .d_trap(d_trap), .d_cause(d_cause), .fw_stall_id(fw_stall_id),
        .fw_branch_correct(fw_branch_correct), .id_branch_predict(id_branch_predict),
        .id_branch_target(id_branch_target), .q_valid(q_valid), .q_pc(q_pc),
        .q_insn(q_insn), .q_trap(q_trap), .q_cause(q_cause), .q_rs1(q_rs1),
        .q_rs2(q_rs2), .q_rd(q_rd), .q_use_rs1(q_use_rs1), .q_use_rs2(q_use_rs2),
        .q_imm(q_imm), .q_predicted(q_predicted)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef enum {F_R, F_I, F_S, F_B, F_U, F_J, F_X} fmt_e;
    typedef struct {
        fmt_e        fmt;
        bit          jal;
        logic [31:0] imm;
        bit          u1, u2, urd;
    } dec_t;

    function automatic dec_t model_decode(input logic [31:0] w);
        dec_t d;
        int   v;
        d.jal = (w[6:0] == 7'h6F);
        case (w[6:0])
            7'h37, 7'h17:                      d.fmt = F_U;
            7'h6F:                             d.fmt = F_J;
            7'h63:                             d.fmt = F_B;
            7'h23:                             d.fmt = F_S;
            7'h33:                             d.fmt = F_R;
            7'h67, 7'h03, 7'h13, 7'h0F, 7'h73: d.fmt = F_I;
            default:                           d.fmt = F_X;
        endcase
        v = 0;
        case (d.fmt)
            F_I: v = $signed(w[31:20]);
            F_S: v = $signed({w[31:25], w[11:7]});
            F_B: v = $signed({w[31], w[7], w[30:25], w[11:8], 1'b0});
            F_U: v = {w[31:12], 12'h000};
            F_J: v = $signed({w[31], w[19:12], w[20], w[30:21], 1'b0});
            default: v = 0;
        endcase
        d.imm = v;
        d.u1  = d.fmt inside {F_R, F_I, F_S, F_B};
        d.u2  = d.fmt inside {F_R, F_S, F_B};
        d.urd = d.fmt inside {F_R, F_I, F_U, F_J};
        return d;
    endfunction

    bit          m_valid = 0, m_trap = 0, m_sent = 0;
    logic [30:0] m_pc;
    logic [31:0] m_insn;
    logic [3:0]  m_cause;

    function automatic bit model_taken();
        dec_t d = model_decode(m_insn);
        if (!m_valid || m_trap || d.fmt == F_X) return 0;
        return d.jal || (d.fmt == F_B && $signed(d.imm) < 0);
    endfunction

    always @(posedge clk) begin
        bit p;
        p = model_taken() && !m_sent && !fw_branch_correct;
        if (rst) begin
            m_valid = 0; m_sent = 0; armed = 1;
        end else if (fw_branch_correct) begin
            m_valid = 0; m_sent = 0;
        end else if (fw_stall_id) begin
            m_sent = m_sent | p;
        end else begin
            m_valid = d_valid; m_pc = d_pc; m_insn = d_insn;
            m_trap = d_trap; m_cause = d_cause; m_sent = 0;
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            dec_t        d;
            bit          tk, ill;
            logic [31:0] byte_tgt;
            d   = model_decode(m_insn);
            tk  = model_taken();
            ill = (d.fmt == F_X);
            chk("q_valid", q_valid, m_valid && !fw_stall_id && !fw_branch_correct);
            chk("predict", id_branch_predict, tk && !m_sent && !fw_branch_correct);
            chk("q_predicted", q_predicted, tk);
            chk("q_trap", q_trap, m_valid && (m_trap || ill));
            chk("q_cause", q_cause, !m_valid ? 0 : m_trap ? m_cause : ill ? 2 : 0);
            if (m_valid) begin
                chk("q_pc", q_pc, m_pc);
                chk("q_insn", q_insn, m_insn);
                chk("q_imm", q_imm, d.imm);
                chk("q_use_rs1", q_use_rs1, d.u1);
                chk("q_use_rs2", q_use_rs2, d.u2);
                chk("q_rs1", q_rs1, d.u1 ? m_insn[19:15] : 0);
                chk("q_rs2", q_rs2, d.u2 ? m_insn[24:20] : 0);
                chk("q_rd", q_rd, d.urd ? m_insn[11:7] : 0);
                if (tk) begin
                    byte_tgt = {m_pc, 1'b0} + d.imm;
                    chk("target", id_branch_target, byte_tgt[31:1]);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    function automatic logic [31:0] rand_insn();
        logic [6:0] ops [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                                 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 5))
            0:       return w;
            1:       return {w[31:7], 7'h6F};
            2:       return {w[31:7], 7'h63};
            3:       return ADDI;
            default: return {w[31:7], ops[$urandom_range(0, 10)]};
        endcase
    endfunction

    initial begin
        rst = 1; d_valid = 1; d_pc = 31'h800; d_insn = JAL8;
        d_trap = 0; d_cause = 0; fw_stall_id = 0; fw_branch_correct = 0;

        // reset held two cycles
        cyc(); settle();
        chk("rst_valid", q_valid, 0);
        chk("rst_predict", id_branch_predict, 0);
        cyc(); settle();
        chk("rst_valid2", q_valid, 0);
        chk("rst_trap", q_trap, 0);
        chk("rst_predicted", q_predicted, 0);
        rst = 0;

        // JAL at 0x1000
        cyc(); settle();
        chk("jal_valid", q_valid, 1);
        chk("jal_predict", id_branch_predict, 1);
        chk("jal_target", id_branch_target, 31'h804);
        chk("jal_imm", q_imm, 8);
        chk("jal_rd", q_rd, 0);
        chk("jal_use_rs1", q_use_rs1, 0);

        // backward then forward branch
        d_insn = 32'hFE000EE3; d_pc = 31'h1000;
        cyc(); settle();
        chk("bwd_predict", id_branch_predict, 1);
        chk("bwd_target", id_branch_target, 31'hFFE);
        chk("bwd_imm", q_imm, 32'hFFFFFFFC);
        d_insn = 32'h00000463;
        cyc(); settle();
        chk("fwd_predict", id_branch_predict, 0);
        chk("fwd_imm", q_imm, 8);
        chk("fwd_predicted", q_predicted, 0);

        // three-cycle stall with JAL in ID
        d_insn = JAL8; d_pc = 31'h800;
        cyc(); fw_stall_id = 1; settle();
        chk("stall1_predict", id_branch_predict, 1);
        chk("stall1_valid", q_valid, 0);
        cyc(); settle();
        chk("stall2_predict", id_branch_predict, 0);
        chk("stall2_valid", q_valid, 0);
        cyc(); settle();
        chk("stall3_predict", id_branch_predict, 0);
        chk("stall3_valid", q_valid, 0);
        fw_stall_id = 0; d_insn = ADDI; settle();
        chk("unstall_valid", q_valid, 1);
        chk("unstall_predict", id_branch_predict, 0);

        // flush with JAL in ID
        d_insn = JAL8;
        cyc(); fw_branch_correct = 1; settle();
        chk("flush_predict", id_branch_predict, 0);
        chk("flush_valid", q_valid, 0);
        cyc(); fw_branch_correct = 0; settle();
        chk("flush_next_valid", q_valid, 0);
        chk("flush_next_predict", id_branch_predict, 0);

        // target wrap-around
        d_pc = 31'h7FFFFFFE; d_insn = JAL8;
        cyc(); cyc(); settle();
        chk("wrap_predict", id_branch_predict, 1);
        chk("wrap_target", id_branch_target, 31'h2);

        // traps
        d_insn = 32'h0;
        cyc(); settle();
        chk("ill_trap", q_trap, 1);
        chk("ill_cause", q_cause, 2);
        chk("ill_predict", id_branch_predict, 0);
        d_trap = 1; d_cause = 4'd1; d_insn = JAL8;
        cyc(); settle();
        chk("ftrap_trap", q_trap, 1);
        chk("ftrap_cause", q_cause, 1);
        chk("ftrap_predict", id_branch_predict, 0);
        d_trap = 0; d_insn = ADDI;
        cyc(); settle();
        chk("addi_trap", q_trap, 0);
        chk("addi_use_rs1", q_use_rs1, 1);
        chk("addi_use_rs2", q_use_rs2, 0);

        // randomized traffic, checked by the model every cycle
        for (int i = 0; i < 3000; i++) begin
            cyc();
            rst               = ($urandom_range(0, 99) < 2);
            d_valid           = ($urandom_range(0, 99) < 85);
            d_pc              = 31'($urandom);
            d_insn            = rand_insn();
            d_trap            = ($urandom_range(0, 99) < 10);
            d_cause           = 4'($urandom);
            fw_stall_id       = ($urandom_range(0, 99) < 25);
            fw_branch_correct = ($urandom_range(0, 99) < 10);
        end
        rst = 0; fw_stall_id = 0; fw_branch_correct = 0;
        cyc(); cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/boa_stage_id.md
# boa_stage_id

Instruction-decode stage of the Boa³² RV32I pipeline. It sits directly downstream of the instruction-fetch stage and consumes its valid/PC/instruction/trap outputs through a one-entry pipeline register. It decodes register indices, immediates and illegal opcodes for the execute stage. It also performs static branch prediction, feeding a predict/target pair back to fetch; the prediction is issued once per instruction.

## Interface

- Parameters: none.
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- d_valid  in  1  fetch output holds an instruction.
- d_pc  in  31  PC bits [31:1] of fetched instruction.
- d_insn  in  32  fetched instruction word.
- d_trap  in  1  fetch raised a trap for this instruction.
- d_cause  in  4  fetch trap cause; meaningful only when d_trap=1.
- fw_stall_id  in  1  hazard unit: hold the ID register.
- fw_branch_correct  in  1  execute mispredict/redirect: flush ID.
- id_branch_predict  out  1  to fetch: redirect to id_branch_target.
- id_branch_target  out  31  predicted target PC bits [31:1].
- q_valid  out  1  ID offers an instruction to execute this cycle.
- q_pc  out  31  PC of the instruction in ID.
- q_insn  out  32  raw instruction in ID.
- q_trap  out  1  fetch trap or illegal instruction.
- q_cause  out  4  trap cause.
- q_rs1, q_rs2, q_rd  out  5 each  register indices; forced to 0 when unused by the format.
- q_use_rs1, q_use_rs2  out  1 each  instruction reads rs1 or rs2.
- q_imm  out  32  sign-extended immediate (I/S/B/U/J); 0 for R-type.
- q_predicted  out  1  this instruction was predicted taken.

## Operation

- ID register fields: r_valid, r_pc, r_insn, r_trap, r_cause, and r_issued (prediction already sent).
- Update priority on each rising edge:
  - rst: r_valid=0, r_issued=0.
  - else fw_branch_correct: r_valid=0, r_issued=0.
  - else fw_stall_id: hold all fields, r_issued |= id_branch_predict.
  - else: capture d_*, r_issued=0.
- Decode is combinational from the ID register. q_pc, q_insn and the decoded fields reflect the register directly.
- q_valid = r_valid & ~fw_stall_id & ~fw_branch_correct.
- Illegal instruction:
  - Triggered by insn[1:0]≠2'b11, or an opcode outside {LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, MISC-MEM, SYSTEM}.
  - Result: q_trap=1, q_cause=4'd2.
  - A fetch trap takes precedence and passes d_cause through unchanged.
- Static prediction: pred_raw = r_valid & ~r_trap & ~illegal & (JAL | (BRANCH & insn[31])).
  - JAL and backward conditional branches are predicted taken.
  - JALR is never predicted.
- id_branch_predict = pred_raw & ~r_issued & ~fw_branch_correct.
- q_predicted = pred_raw.
- id_branch_target = r_pc + imm[31:1], where imm is J-immediate for JAL and B-immediate for BRANCH. Sum is modulo 2^31 (wraps silently).
- ID does not squash the sequentially fetched successor; fetch discards it on id_branch_predict.

## Timing

- Latency: an instruction captured at edge N appears on q_* during cycle N..N+1.
- One instruction per cycle when unstalled.
- Reset values: q_valid=0, id_branch_predict=0, q_trap=0, q_predicted=0. Remaining outputs decode r_insn, which is don't-care while q_valid=0.
- Stall: q_valid is 0 every stalled cycle. id_branch_predict may assert in the first stalled cycle, and never again for the same instruction.
- Flush and stall together: flush wins, and the register is cleared.
- Flush in the same cycle as a fresh capture: the capture is dropped.
- Reset mid-stall: clears the register, and r_issued is cleared.

## Test plan

- **Reset:** hold rst=1 for 2 cycles with d_valid=1, d_insn=0x0080006F.
  - During reset: q_valid=0, id_branch_predict=0.
  - After release with d_valid=1: q_valid=1 the next cycle.
- **JAL:** d_pc=0x1000>>1, d_insn=0x0080006F.
  - Next cycle: id_branch_predict=1, target=0x1008>>1, q_imm=8, q_rd=0, q_use_rs1=0.
- **Conditional branches:**
  - 0xFE000EE3 (beq -4) at PC 0x2000 → predict=1, target=0x1FFC>>1, q_imm=0xFFFFFFFC.
  - 0x00000463 (beq +8) → predict=0, q_imm=8, q_predicted=0.
- **Stall, then flush:**
  - JAL in ID, fw_stall_id=1 for 3 cycles → predict=1 in cycle 1 only; q_valid=0 for 3 cycles, then 1.
  - Separately, fw_branch_correct=1 while JAL sits in ID → predict=0 that cycle; q_valid=0 that cycle and the next.
- **Wrap-around:** JAL +8 at PC 0xFFFFFFFC → target=0x00000004>>1.
- **Traps:**
  - d_insn=0x00000000 → q_trap=1, q_cause=2, predict=0.
  - d_trap=1 with d_cause=1 and a JAL word → q_cause=1, predict=0.
  - Word 0x00000013 (addi) → q_trap=0, q_use_rs1=1, q_use_rs2=0.
